// File: rtl/msg_arbiter_rr.sv
// Round-robin message arbiter: grants one source at a time and serialises its message
// as a SYNC/ADDR/LEN/PAYLOAD/CSUM byte frame onto a valid/ready UART byte stream.
module msg_arbiter_rr #(
  parameter int         N_SRC     = 25,
  parameter logic [7:0] SYNC_BYTE = 8'hAA,
  parameter bit         CSUM_EN   = 1'b1
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [N_SRC-1:0]   have_msg_bus,
  input  logic [8*N_SRC-1:0] data_bus,
  input  logic [8*N_SRC-1:0] len_bus,
  output logic [N_SRC-1:0]   rdreq_bus,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic [4:0]         grant_idx
);

  localparam int unsigned IDX_W = 5;

  typedef enum logic [2:0] {IDLE, SYNC, ADDR, LEN, PAYLOAD, CSUM} state_t;

  state_t           state, state_nxt;
  logic [7:0]       tx_data_nxt;
  logic             tx_valid_nxt, busy_nxt;
  logic [IDX_W-1:0] grant_nxt, last_grant, last_nxt;
  logic [7:0]       len_q, len_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [7:0]       csum, csum_nxt;
  logic             load_pl;
  logic             accept;

  logic             found_hi, found_lo;
  logic [IDX_W-1:0] pick_hi, pick_lo, pick;
  logic [7:0]       pick_len, sel_data;
  logic [N_SRC-1:0] rd_c;

  assign accept = tx_valid & tx_ready;

  // Round-robin search: first requester above last_grant, else first at or below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (have_msg_bus[i] && (i > int'(last_grant)) && !found_hi) begin
        found_hi = 1'b1;
        pick_hi  = IDX_W'(i);
      end
      if (have_msg_bus[i] && (i <= int'(last_grant)) && !found_lo) begin
        found_lo = 1'b1;
        pick_lo  = IDX_W'(i);
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  // Byte lane muxes for the candidate's length and the granted source's data.
  always_comb begin
    pick_len = '0;
    sel_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (pick == IDX_W'(i))      pick_len = len_bus[8*i +: 8];
      if (grant_idx == IDX_W'(i)) sel_data = data_bus[8*i +: 8];
    end
  end

  // Next-state and next-register logic; nothing moves while a byte is stalled.
  always_comb begin
    state_nxt    = state;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = tx_valid;
    busy_nxt     = busy;
    grant_nxt    = grant_idx;
    last_nxt     = last_grant;
    len_nxt      = len_q;
    cnt_nxt      = cnt;
    csum_nxt     = csum;
    load_pl      = 1'b0;

    unique case (state)
      IDLE: begin
        if (found_hi || found_lo) begin
          grant_nxt    = pick;
          last_nxt     = pick;
          len_nxt      = pick_len;
          csum_nxt     = 8'(pick) ^ pick_len;
          cnt_nxt      = '0;
          tx_data_nxt  = SYNC_BYTE;
          tx_valid_nxt = 1'b1;
          busy_nxt     = 1'b1;
          state_nxt    = SYNC;
        end
      end
      SYNC: begin
        if (accept) begin
          tx_data_nxt = 8'(grant_idx);
          state_nxt   = ADDR;
        end
      end
      ADDR: begin
        if (accept) begin
          tx_data_nxt = len_q;
          state_nxt   = LEN;
        end
      end
      LEN, PAYLOAD: begin
        if (accept) begin
          if ((state == LEN && len_q != 8'd0) || (state == PAYLOAD && cnt != len_q)) begin
            load_pl     = 1'b1;
            tx_data_nxt = sel_data;
            csum_nxt    = csum ^ sel_data;
            cnt_nxt     = cnt + 8'd1;
            state_nxt   = PAYLOAD;
          end else if (CSUM_EN) begin
            tx_data_nxt = csum;
            state_nxt   = CSUM;
          end else begin
            tx_valid_nxt = 1'b0;
            busy_nxt     = 1'b0;
            state_nxt    = IDLE;
          end
        end
      end
      CSUM: begin
        if (accept) begin
          tx_valid_nxt = 1'b0;
          busy_nxt     = 1'b0;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pop strobe coincides with the load so the show-ahead byte advances at the same edge.
  always_comb begin
    rd_c = '0;
    for (int i = 0; i < N_SRC; i++) begin
      rd_c[i] = load_pl && (grant_idx == IDX_W'(i));
    end
  end

  assign rdreq_bus = n_rst ? rd_c : '0;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      grant_idx  <= '0;
      last_grant <= IDX_W'(N_SRC - 1);
      len_q      <= '0;
      cnt        <= '0;
      csum       <= '0;
    end else begin
      state      <= state_nxt;
      tx_data    <= tx_data_nxt;
      tx_valid   <= tx_valid_nxt;
      busy       <= busy_nxt;
      grant_idx  <= grant_nxt;
      last_grant <= last_nxt;
      len_q      <= len_nxt;
      cnt        <= cnt_nxt;
      csum       <= csum_nxt;
    end
  end

endmodule

// File: tb/tb_msg_arbiter_rr.sv
// Directed bench for msg_arbiter_rr: source models, byte monitors, and a linear test sequence.
module tb_msg_arbiter_rr;

  localparam int N = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           n_rst;
  logic [N-1:0]   have;
  logic [8*N-1:0] data_bus, len_bus;
  logic [N-1:0]   rdreq;
  logic [7:0]     tx_data;
  logic           tx_valid, tx_ready, busy;
  logic [4:0]     grant_idx;

  logic [1:0]  have0;
  logic [15:0] data0, len0;
  logic [1:0]  rdreq0;
  logic [7:0]  tx_data0;
  logic        tx_valid0, busy0;
  logic [4:0]  grant0;

  logic [7:0] mem [N][256];
  logic [7:0] len_arr [N];
  logic [7:0] ptr [N];

  msg_arbiter_rr #(.N_SRC(N), .SYNC_BYTE(8'hAA), .CSUM_EN(1'b1)) dut (
    .clk(clk), .n_rst(n_rst), .have_msg_bus(have), .data_bus(data_bus), .len_bus(len_bus),
    .rdreq_bus(rdreq), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .grant_idx(grant_idx)
  );

  msg_arbiter_rr #(.N_SRC(2), .SYNC_BYTE(8'hAA), .CSUM_EN(1'b0)) dut0 (
    .clk(clk), .n_rst(n_rst), .have_msg_bus(have0), .data_bus(data0), .len_bus(len0),
    .rdreq_bus(rdreq0), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(1'b1),
    .busy(busy0), .grant_idx(grant0)
  );

  assign data0 = {8'h7E, 8'h00};
  assign len0  = {8'h01, 8'h00};

  // Show-ahead source FIFOs.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      data_bus[8*i +: 8] = mem[i][ptr[i]];
      len_bus[8*i +: 8]  = len_arr[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!n_rst)        ptr[i] <= 8'd0;
      else if (rdreq[i]) ptr[i] <= ptr[i] + 8'd1;
    end
  end

  logic [7:0] q[$];
  logic [7:0] q0[$];
  logic [4:0] gq[$];
  int         rd_cnt [N];
  int         oh_err, stall_err;
  logic       pv, pr, pb;
  logic [7:0] pd;

  always @(posedge clk) begin
    if (!n_rst) begin
      pv <= 1'b0;
      pr <= 1'b0;
      pb <= 1'b0;
    end else begin
      if (tx_valid && tx_ready) q.push_back(tx_data);
      if (tx_valid0)            q0.push_back(tx_data0);
      if (busy && !pb)          gq.push_back(grant_idx);
      for (int i = 0; i < N; i++) if (rdreq[i]) rd_cnt[i]++;
      if (rdreq != '0 && rdreq != (N'(1) << grant_idx)) oh_err++;
      if (pv && !pr && (!tx_valid || tx_data !== pd))   stall_err++;
      pv <= tx_valid;
      pr <= tx_ready;
      pd <= tx_data;
      pb <= busy;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [7:0] exp[$]);
    chk({tag, "_len"}, 32'(q.size() - base), 32'(exp.size()));
    for (int k = 0; k < exp.size(); k++) begin
      if (base + k < q.size()) chk($sformatf("%s_b%0d", tag, k), 32'(q[base+k]), 32'(exp[k]));
    end
  endtask

  initial begin
    int         base, r, t, gbase;
    logic [7:0] exp[$];
    logic [7:0] cs;

    for (int i = 0; i < N; i++) begin
      len_arr[i] = 8'd0;
      for (int k = 0; k < 256; k++) mem[i][k] = 8'(i * 16 + k);
    end
    mem[3][0] = 8'h11;
    mem[3][1] = 8'h22;
    for (int k = 0; k < 256; k++) mem[7][k] = 8'(k * 37 + 5);
    have     = '0;
    have0    = '0;
    tx_ready = 1'b1;
    n_rst    = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_data",  32'(tx_data),  0);
    chk("rst_busy",  32'(busy),     0);
    chk("rst_grant", 32'(grant_idx), 0);
    chk("rst_rdreq", 32'(rdreq),    0);
    n_rst = 1'b1;
    @(negedge clk);

    // Source 3, two bytes; checksum 03^02^11^22.
    base = q.size(); r = rd_cnt[3];
    len_arr[3] = 8'd2; have[3] = 1'b1;
    @(negedge clk);
    chk("a_grant", 32'(grant_idx), 3);
    chk("a_busy",  32'(busy), 1);
    have = '0;
    wait_idle("a");
    exp = '{8'hAA, 8'h03, 8'h02, 8'h11, 8'h22, 8'h32};
    check_frame("a", base, exp);
    chk("a_rdreq", 32'(rd_cnt[3] - r), 2);

    // Source 5, empty payload.
    base = q.size(); r = rd_cnt[5];
    have[5] = 1'b1;
    @(negedge clk);
    have = '0;
    wait_idle("b");
    exp = '{8'hAA, 8'h05, 8'h00, 8'h05};
    check_frame("b", base, exp);
    chk("b_rdreq", 32'(rd_cnt[5] - r), 0);

    // Sources 0..2 continuously requesting rotate fairly.
    len_arr[0] = 8'd1; len_arr[1] = 8'd1; len_arr[2] = 8'd1;
    gbase = gq.size();
    have[2:0] = 3'b111;
    t = 0;
    while (gq.size() - gbase < 6 && t < 500) begin
      @(negedge clk);
      t++;
    end
    have = '0;
    wait_idle("c");
    chk("c_count", 32'(gq.size() - gbase), 6);
    for (int k = 0; k < 6; k++) begin
      if (gbase + k < gq.size()) chk($sformatf("c_order%0d", k), 32'(gq[gbase+k]), 32'(k % 3));
    end

    // Source 7, 255 bytes under random back-pressure.
    base = q.size();
    len_arr[7] = 8'd255;
    cs = 8'h07 ^ 8'hFF;
    exp = '{8'hAA, 8'h07, 8'hFF};
    for (int k = 0; k < 255; k++) begin
      exp.push_back(mem[7][k]);
      cs = cs ^ mem[7][k];
    end
    exp.push_back(cs);
    have[7] = 1'b1;
    @(negedge clk);
    have = '0;
    t = 0;
    while (busy && t < 5000) begin
      tx_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      t++;
    end
    tx_ready = 1'b1;
    wait_idle("d");
    check_frame("d", base, exp);
    chk("d_stall", 32'(stall_err), 0);

    // Reset while the third payload byte of source 4 is on the line.
    len_arr[4] = 8'd10; r = rd_cnt[4];
    have[4] = 1'b1;
    @(negedge clk);
    have = '0;
    t = 0;
    while (rd_cnt[4] - r < 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_rst = 1'b0;
    @(negedge clk);
    chk("e_valid", 32'(tx_valid), 0);
    chk("e_busy",  32'(busy), 0);
    chk("e_rdreq", 32'(rdreq), 0);
    chk("e_pops",  32'(rd_cnt[4] - r), 3);
    n_rst = 1'b1;
    base = q.size();
    have[0] = 1'b1; have[4] = 1'b1;
    @(negedge clk);
    chk("e_grant", 32'(grant_idx), 0);
    have = '0;
    wait_idle("e");
    chk("e_len", 32'(q.size() - base), 5);
    if (base + 1 < q.size()) begin
      chk("e_sync", 32'(q[base]), 32'hAA);
      chk("e_addr", 32'(q[base+1]), 0);
    end

    // No-checksum instance, source 1, one byte.
    have0 = 2'b10;
    @(negedge clk);
    chk("f_grant", 32'(grant0), 1);
    have0 = '0;
    t = 0;
    while (q0.size() < 4 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("f_len",  32'(q0.size()), 4);
    chk("f_busy", 32'(busy0), 0);
    exp = '{8'hAA, 8'h01, 8'h01, 8'h7E};
    for (int k = 0; k < 4; k++) begin
      if (k < q0.size()) chk($sformatf("f_b%0d", k), 32'(q0[k]), 32'(exp[k]));
    end
    repeat (3) @(negedge clk);
    chk("f_nomore", 32'(q0.size()), 4);

    chk("onehot", 32'(oh_err), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
